// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame length and bit-timing helpers
// used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

   // start + 8 data + stop
   localparam int FRAME_BITS = 10;

   function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a registered
// falling-edge detector on the synchronized level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_pin,
   output logic rx_sync,
   output logic fall
);

   logic sync1_r;
   logic sync2_r;
   logic fall_r;

   // Synchronizer chain; fall_r marks the cycle in which sync2_r goes 1 -> 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         fall_r  <= 1'b0;
      end else begin
         sync1_r <= rx_pin;
         sync2_r <= sync1_r;
         fall_r  <= sync2_r & ~sync1_r;
      end
   end

   assign rx_sync = sync2_r;
   assign fall    = fall_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: samples mid-bit, hands bytes over a valid/ready
// interface and reports framing errors and overruns as one-cycle pulses.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 921600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_error,
   output logic       overrun
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF_BIT       = half_bit(CYCLES_PER_BIT);
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;

   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT     = 3'(FRAME_BITS - 3);

   if (CYCLES_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
   end

   logic rx_sync_s;
   logic fall_s;

   uart_rx_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx_pin  (rx_pin),
      .rx_sync (rx_sync_s),
      .fall    (fall_s)
   );

   uart_state_e      state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [2:0]       bit_idx_r, bit_idx_s;
   logic [7:0]       shift_r, shift_s;
   logic [7:0]       data_r, data_s;
   logic             valid_r, valid_s;
   logic             busy_r, busy_s;
   logic             frame_error_r, frame_error_s;
   logic             overrun_r, overrun_s;

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= CNT_ZERO;
         bit_idx_r     <= 3'd0;
         shift_r       <= 8'h00;
         data_r        <= 8'h00;
         valid_r       <= 1'b0;
         busy_r        <= 1'b0;
         frame_error_r <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         bit_idx_r     <= bit_idx_s;
         shift_r       <= shift_s;
         data_r        <= data_s;
         valid_r       <= valid_s;
         busy_r        <= busy_s;
         frame_error_r <= frame_error_s;
         overrun_r     <= overrun_s;
      end
   end

   // Next-state and output logic; a good stop sample either loads the byte or,
   // if the consumer is still holding the previous one, drops it as an overrun.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r + CNT_ONE;
      bit_idx_s     = bit_idx_r;
      shift_s       = shift_r;
      data_s        = data_r;
      frame_error_s = 1'b0;
      overrun_s     = 1'b0;
      if (valid_r && rx_ready) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end

      case (state_r)
         IDLE: begin
            cnt_s = CNT_ZERO;
            if (fall_s) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (cnt_r == CNT_HALF_END) begin
               cnt_s = CNT_ZERO;
               if (!rx_sync_s) begin
                  state_s   = DATA;
                  bit_idx_s = 3'd0;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (cnt_r == CNT_BIT_END) begin
               cnt_s   = CNT_ZERO;
               shift_s = {rx_sync_s, shift_r[7:1]};
               if (bit_idx_r == LAST_BIT) begin
                  state_s = STOP;
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               state_s = DATA;
            end
         end
         STOP: begin
            if (cnt_r == CNT_BIT_END) begin
               cnt_s = CNT_ZERO;
               if (rx_sync_s) begin
                  state_s = IDLE;
                  if (!valid_r || rx_ready) begin
                     data_s  = shift_r;
                     valid_s = 1'b1;
                  end else begin
                     overrun_s = 1'b1;
                  end
               end else begin
                  frame_error_s = 1'b1;
                  state_s       = BREAK;
               end
            end else begin
               state_s = STOP;
            end
         end
         BREAK: begin
            cnt_s = CNT_ZERO;
            if (rx_sync_s) begin
               state_s = IDLE;
            end else begin
               state_s = BREAK;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   assign rx_data     = data_r;
   assign rx_valid    = valid_r;
   assign rx_busy     = busy_r;
   assign frame_error = frame_error_r;
   assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: hand-built 8N1 frames on rx_pin, a
// frame-level reference model and a per-cycle comparison of all outputs.
module tb_uart_receiver;

   localparam int CPB  = 54;   // 50_000_000 / 921600
   localparam int HALF = 27;
   // raw fall -> stop-sample edge: 2 sync + 1 detect + HALF + 9 bit periods
   localparam int STOP_LAT = 3 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_pin = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_error;
   logic       overrun;

   uart_receiver dut (
      .clk         (clk),
      .rst         (rst),
      .rx_pin      (rx_pin),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_busy     (rx_busy),
      .frame_error (frame_error),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [7:0] data;
      logic       ok;
   } frame_t;

   frame_t     q[$];
   int         cyc = 0;
   logic       m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_fe = 1'b0;
   logic       m_ov = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   int n_vcyc = 0;
   int n_fe = 0;
   int n_ov = 0;
   logic chk_en = 1'b0;

   // Reference model: a completed frame either delivers, overruns or errors.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         m_fe    <= 1'b0;
         m_ov    <= 1'b0;
         q.delete();
      end else begin
         m_fe <= 1'b0;
         m_ov <= 1'b0;
         if (m_valid && rx_ready) m_valid <= 1'b0;
         if (q.size() != 0 && q[0].due == cyc + 1) begin
            if (!q[0].ok) begin
               m_fe <= 1'b1;
            end else if (!m_valid || rx_ready) begin
               m_data  <= q[0].data;
               m_valid <= 1'b1;
            end else begin
               m_ov <= 1'b1;
            end
            void'(q.pop_front());
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
            check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
            check("frame_error", {31'd0, frame_error}, {31'd0, m_fe});
            check("overrun", {31'd0, overrun}, {31'd0, m_ov});
            if (rx_valid === 1'b1) n_vcyc++;
            if (frame_error === 1'b1) n_fe++;
            if (overrun === 1'b1) n_ov++;
         end
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_vcyc = 0;
      n_fe   = 0;
      n_ov   = 0;
   endtask

   // Drives one frame; the line is left at the stop level afterwards.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      q.push_back('{due: cyc + STOP_LAT, data: b, ok: stop});
      rx_pin = 1'b0;
      hold(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         hold(CPB);
      end
      rx_pin = stop;
      hold(CPB);
   endtask

   initial begin
      int due;
      fork
         compare_loop();
      join_none

      hold(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset rx_data", {24'd0, rx_data}, 32'h00);
      check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset rx_busy", {31'd0, rx_busy}, 32'd0);
      check("reset frame_error", {31'd0, frame_error}, 32'd0);
      check("reset overrun", {31'd0, overrun}, 32'd0);
      hold(5);

      // Consumer always ready
      clear_counts();
      send_frame(8'h55, 1'b1);
      hold(20);
      check("0x55 data", {24'd0, rx_data}, 32'h55);
      check("0x55 valid cycles", n_vcyc, 32'd1);
      send_frame(8'hAA, 1'b1);
      hold(20);
      check("0xAA data", {24'd0, rx_data}, 32'hAA);
      check("0xAA valid cycles", n_vcyc, 32'd2);
      check("ready errors", n_fe + n_ov, 32'd0);

      // Stalled consumer, back-to-back frames
      rx_ready = 1'b0;
      clear_counts();
      send_frame(8'hAA, 1'b1);
      send_frame(8'hA2, 1'b1);
      hold(20);
      check("stall valid", {31'd0, rx_valid}, 32'd1);
      check("stall data", {24'd0, rx_data}, 32'hAA);
      check("stall overrun pulses", n_ov, 32'd1);
      rx_ready = 1'b1;
      hold(1);
      check("accept drops valid", {31'd0, rx_valid}, 32'd0);

      // Short glitch is a false start
      clear_counts();
      rx_pin = 1'b0;
      hold(10);
      check("glitch busy", {31'd0, rx_busy}, 32'd1);
      rx_pin = 1'b1;
      hold(30);
      check("glitch idle", {31'd0, rx_busy}, 32'd0);
      check("glitch outputs", n_vcyc + n_fe, 32'd0);

      // Framing error followed by a break
      clear_counts();
      send_frame(8'h3C, 1'b0);
      hold(5 * CPB);
      check("break busy", {31'd0, rx_busy}, 32'd1);
      check("break fe pulses", n_fe, 32'd1);
      check("break no valid", n_vcyc, 32'd0);
      rx_pin = 1'b1;
      hold(4);
      check("break released", {31'd0, rx_busy}, 32'd0);
      send_frame(8'h81, 1'b1);
      hold(20);
      check("after break data", {24'd0, rx_data}, 32'h81);
      check("after break valid cycles", n_vcyc, 32'd1);

      // Reset during data bit 4 of 0x55; the sender is abandoned with the line high
      rx_pin = 1'b0;
      hold(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_pin = ((i % 2) == 0) ? 1'b1 : 1'b0;
         hold(CPB);
      end
      rx_pin = 1'b1;
      hold(CPB / 2);
      rst = 1'b1;
      hold(1);
      rst = 1'b0;
      check("midreset rx_data", {24'd0, rx_data}, 32'h00);
      check("midreset rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midreset rx_busy", {31'd0, rx_busy}, 32'd0);
      check("midreset pulses", {30'd0, frame_error, overrun}, 32'd0);
      clear_counts();
      hold(5 * CPB);
      check("midreset quiet", n_vcyc + n_fe + n_ov, 32'd0);
      send_frame(8'h81, 1'b1);
      hold(20);
      check("after reset data", {24'd0, rx_data}, 32'h81);

      // Accept coinciding with the next stop sample
      rx_ready = 1'b0;
      clear_counts();
      send_frame(8'h11, 1'b1);
      hold(10);
      check("held 0x11", {24'd0, rx_data}, 32'h11);
      due = cyc + STOP_LAT;
      fork
         send_frame(8'h22, 1'b1);
         begin
            hold(due - 1 - cyc);
            rx_ready = 1'b1;
            hold(1);
            rx_ready = 1'b0;
         end
      join
      hold(20);
      check("simul data", {24'd0, rx_data}, 32'h22);
      check("simul valid", {31'd0, rx_valid}, 32'd1);
      check("simul overrun", n_ov, 32'd0);
      rx_ready = 1'b1;
      hold(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; directly downstream of uart_transmitter.
- Consumes the serial line that uart_transmitter drives on tx_pin.
- Delivers bytes to a parallel consumer over a valid/ready handshake, format 8N1, LSB first.
- Flags framing errors, and overruns when the consumer stalls.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 921600, line bit rate in bits/s.
- Derived constant (not overridable) CYCLES_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide; 54 at defaults).
- Derived constant (not overridable) HALF_BIT = CYCLES_PER_BIT/2 (27 at defaults).

Ports:
- clk  in  1  system clock. One clock only.
- rst  in  1  reset, synchronous, active-high.
- rx_pin  in  1  asynchronous serial input; idle high.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready at a rising clk edge.
- rx_busy  out  1  high while the FSM is outside IDLE.
- frame_error  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: a good byte completed while the previous byte was still unaccepted.

Behaviour:
- Reset (sampled at posedge clk while rst=1):
  - rx_data=0, rx_valid=0, rx_busy=0, frame_error=0, overrun=0.
  - FSM goes to IDLE; bit and cycle counters clear.
  - Synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame silently; no pulses are generated.
- Input conditioning:
  - rx_pin passes through a 2-flop synchronizer.
  - A falling edge is detected on the synchronized signal (previous=1, current=0).
- FSM states and transitions:
  - IDLE: on a detected falling edge, go to START and clear the cycle counter.
  - START: count HALF_BIT cycles, then sample. Line 0: go to DATA (bit index 0, counter cleared). Line 1: false start, return to IDLE with no outputs.
  - DATA: sample every CYCLES_PER_BIT cycles into a shift register, LSB first, 8 samples. After bit 7, go to STOP.
  - STOP: sample after CYCLES_PER_BIT cycles.
    - Sample 1: good frame; go to IDLE.
    - Sample 0: frame_error pulses on the next cycle; byte is discarded; go to BREAK.
  - BREAK: wait for synchronized line = 1, then IDLE. A held-low line never starts a new frame.
- Timing:
  - Sample points fall at HALF_BIT + k*CYCLES_PER_BIT cycles after edge detection, k=0..9.
  - Edge detection occurs 2 cycles after the raw rx_pin fall.
- Output on a good stop sample (takes effect at the next edge):
  - rx_valid=0, or rx_ready=1 in that same cycle: rx_data loads the new byte and rx_valid=1. No overrun; back-to-back accept and fill is legal.
  - rx_valid=1 and rx_ready=0: new byte is dropped, rx_data keeps the old byte, overrun pulses for 1 cycle.
  - Otherwise, rx_valid && rx_ready clears rx_valid at the next edge.
- rx_data changes only on a load. rx_data does not change on accept or error.
- Counter widths: $clog2(CYCLES_PER_BIT)+1 bits for the cycle counter; 3 bits for the bit index.
- CYCLES_PER_BIT < 4 is a parameter error; flag it with an elaboration-time $error.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE, START, DATA, STOP, BREAK.
  - The CYCLES_PER_BIT/HALF_BIT calculation, shared with uart_transmitter.
  - The frame-length constant 10.
- One sub-module: uart_rx_sync, containing the 2-flop synchronizer plus falling-edge detect.
  - Outputs: rx_sync, fall.
  - Resets to 1 / 0.
- Everything else lives in uart_receiver.

Test Plan:
- Loopback: uart_transmitter tx_pin drives rx_pin, defaults 50 MHz / 921600, rx_ready=1. Send 0x55 → rx_valid high exactly 1 cycle, rx_data=0x55, no frame_error/overrun. Repeat with 0xAA.
- Stall: rx_ready=0, send 0xAA then 0xA2 back-to-back → rx_valid stays 1, rx_data=0xAA, overrun pulses once at the second stop sample. Then raise rx_ready → rx_valid drops next cycle.
- Glitch: drive rx_pin low for 10 cycles (< HALF_BIT=27) → FSM returns to IDLE, rx_busy drops, no rx_valid or frame_error.
- Framing/break: hand-drive a 0x3C frame with stop bit 0, then hold the line low 5 bit periods → frame_error pulses once, rx_valid stays 0. No new frame starts until the line returns high. A following 0x81 is then received correctly.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0x55 → next cycle all outputs 0 and rx_busy=0. No pulse. A subsequent 0x81 is received correctly.
- Simultaneous accept/complete: hold rx_valid (0x11) and pulse rx_ready exactly in the cycle of 0x22's stop sample → rx_data=0x22, rx_valid=1, overrun=0.
